// File: rtl/salidas_uart_tx_if.sv
// Bus bundle between the MIPS core's salidas output and the UART trace transmitter.
interface salidas_uart_tx_if #(
  parameter int unsigned FIFO_AW = 2
);
  logic [8:0]       salidas;
  logic             tx;
  logic             busy;
  logic             overflow;
  logic [FIFO_AW:0] fifo_count;

  modport master (output salidas, input tx, busy, overflow, fifo_count);
  modport slave  (input salidas, output tx, busy, overflow, fifo_count);
endinterface

// File: rtl/salidas_uart_tx.sv
// Queues every change of the 9-bit salidas bus and sends it as two UART bytes on tx.
// Optional 8E1 framing when SALIDAS_UART_PARITY_EN is defined.
module salidas_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic             clk,
  input  logic             rst,
  salidas_uart_tx_if.slave bus
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

`ifdef SALIDAS_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state, state_n;
  logic [CNT_W-1:0] baud, baud_n;
  logic [2:0]       bit_idx, bit_n;
  logic             byte_sel, sel_n;
  logic [8:0]       hold, hold_n;
  logic             tx_q, tx_n;
  logic [7:0]       cur_n;
  logic             bit_done;

  logic [8:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [8:0]         last_q;
  logic               ovf_q;
  logic               change, full, pop, push;

  assign change = (bus.salidas != last_q);
  assign full   = (count == (FIFO_AW+1)'(DEPTH));
  assign pop    = (state == IDLE) && (count != '0);
  // A pop in the same edge frees a slot, so a full FIFO can still accept.
  assign push   = change && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (change)         last_q <= bus.salidas;
      if (push)           wr_ptr <= wr_ptr + 1'b1;
      if (pop)            rd_ptr <= rd_ptr + 1'b1;
      if (change && !push) ovf_q <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.salidas;
  end

  assign bit_done = (baud == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n = state;
    baud_n  = bit_done ? '0 : baud + 1'b1;
    bit_n   = bit_idx;
    sel_n   = byte_sel;
    hold_n  = hold;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (pop) begin
          hold_n  = mem[rd_ptr];
          sel_n   = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
`ifdef SALIDAS_UART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
`ifdef SALIDAS_UART_PARITY_EN
      PARITY: begin
        if (bit_done) state_n = STOP;
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (!byte_sel) begin
            sel_n   = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // tx is registered, so it is derived from the state being entered.
    cur_n = sel_n ? {1'b1, 6'b000000, hold_n[8]} : hold_n[7:0];
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = cur_n[bit_n];
`ifdef SALIDAS_UART_PARITY_EN
      PARITY:  tx_n = ^cur_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      byte_sel <= 1'b0;
      hold     <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_idx  <= bit_n;
      byte_sel <= sel_n;
      hold     <= hold_n;
      tx_q     <= tx_n;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = (state != IDLE);
  assign bus.overflow   = ovf_q;
  assign bus.fifo_count = count;
endmodule

// File: doc/salidas_uart_tx.md
Name: salidas_uart_tx

Overview:
- Downstream consumer of the MIPS core's 9-bit `salidas` output bus.
- Detects every change on `salidas` and queues the new value in a small FIFO.
- Serialises each queued value as a two-byte 8N1 UART frame pair on `tx`.
- Gives lab boards and simulation benches a single-pin trace of processor output activity.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (must be ≥2).
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries of 9 bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- salidas  in  9  output bus from the MIPS core; sampled every cycle.
- tx  out  1  UART serial line; idle high.
- busy  out  1  high while the transmit FSM is not IDLE.
- overflow  out  1  sticky; set when a change is dropped because the FIFO is full.
- fifo_count  out  FIFO_AW+1  number of entries currently queued.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx=1, busy=0, overflow=0, fifo_count=0.
  - FSM=IDLE; last_q=9'h000; FIFO pointers cleared.
  - Reset mid-frame aborts the frame immediately; no partial byte is resumed.
- Change detect:
  - At each rising edge where salidas != last_q: last_q <= salidas, and a push of salidas is requested.
  - A bus held at 9'h000 from reset sends nothing.
- FIFO:
  - Push accepted if not full, or if a pop occurs in the same edge; otherwise the value is dropped and overflow <= 1.
  - overflow is cleared only by reset.
  - Pointers wrap modulo 2**FIFO_AW; fifo_count is updated in the same edge as the push/pop.
  - Simultaneous push and pop leaves the count unchanged.
- Frame format per sample:
  - byte0 = salidas[7:0].
  - byte1 = {1'b1, 6'b000000, salidas[8]}, i.e. 8'h80 or 8'h81; bit 7 marks the second byte.
  - Each byte is: start bit 0, 8 data bits LSB first, stop bit 1. Every bit lasts exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when fifo_count != 0, pop the head into a 9-bit hold register, byte_sel=0, go to START. The pop occurs at the first edge the FIFO is non-empty, i.e. one cycle after the push.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx=current byte[bit_idx]; after 8 bits go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte_sel=0: byte_sel=1, go to START;
    - else go to IDLE.
    - No idle gap is inserted between the two bytes of a sample.
- Timing and outputs:
  - tx is registered (glitch-free).
  - A sample occupies 20 bit times = 20*CLKS_PER_BIT cycles.
  - Back-to-back samples are separated by exactly one IDLE cycle.
  - busy=1 from the edge leaving IDLE until the edge returning to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, resets on every state/bit change; width is $clog2(CLKS_PER_BIT).

Optional Feature:
- Macro SALIDAS_UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - tx = even parity (XOR of the 8 data bits), giving 8E1 framing.
  - A sample takes 22 bit times.
- Undefined: no PARITY state; 8N1 framing as above.

Test Plan:
- Reset release: rst=0 for 2 cycles then 1, with salidas=0 held for 500 cycles -> tx stays 1, busy=0, fifo_count=0, overflow=0.
- Single change: salidas 0->9'h0A5 -> tx emits start, bits 1,0,1,0,0,1,0,1, stop, then start, 0x80 LSB-first, stop. Total 320 cycles with CLKS_PER_BIT=16; busy falls at cycle 321 after the push.
- Bit 8 path: salidas=9'h13C -> bytes 0x3C then 0x81.
- Overflow: salidas takes values 1,2,3,4,5,6 on consecutive cycles -> samples 1–5 transmitted in order; 6 dropped; overflow=1 remains set after the FIFO drains; fifo_count peaks at 4.
- Reset mid-frame: assert rst during DATA of byte0 -> tx=1 and busy=0 without waiting for a clock; after release, with salidas unchanged from last_q's reset value, no frame follows.
- Parity build (SALIDAS_UART_PARITY_EN): salidas=9'h007 -> byte0 parity bit=1, byte1 (0x80) parity bit=1; sample length 352 cycles.
